uart_transmitter: RTL
=====================

Name: uart_transmitter

Overview:
TX serializer of the UART peripheral, directly downstream of the TX buffer FIFO that the TX_BUFFER register write path fills. Pops one byte per frame from the FIFO (first-word-fall-through). Drives uart_tx_o as start bit, data LSB-first, optional parity and 1 or 2 stop bits, with optional CTS flow control. Timing comes from a 16x-oversampled tick derived from the STATUS clock divider; divider 53 at 100 MHz gives about 115200 baud.

Parameters:
DATA_WIDTH, 8, data bits per frame.
OVERSAMPLE, 16, ticks per bit; fixed, exported from the package.

Ports:
clk_i  input  1  system clock
rst_n_i  input  1  asynchronous active-low reset
clock_divider_i  input  15  tick period = clock_divider_i+1 cycles
parity_enable_i  input  1  append parity bit
parity_odd_i  input  1  1 = odd parity, 0 = even parity
stop_bits_i  input  1  0 = one stop bit, 1 = two stop bits
flow_control_i  input  1  honour uart_cts_i
uart_cts_i  input  1  clear-to-send from peer, active-high
fifo_empty_i  input  1  TX FIFO empty
fifo_data_i  input  DATA_WIDTH  TX FIFO head word
fifo_read_o  output  1  pop strobe, one cycle
uart_tx_o  output  1  serial line, idles high
tx_done_o  output  1  one-cycle pulse at end of last stop bit
idle_o  output  1  state is IDLE

Behaviour:
- Clock is clk_i only. Reset is asynchronous, active-low, on rst_n_i.
- Reset values: uart_tx_o=1, fifo_read_o=0, tx_done_o=0, idle_o=1, state IDLE, tick and bit counters cleared.
- Tick generator counts 0..clock_divider_i and emits a one-cycle tick on wrap. It is cleared on leaving IDLE, so the first tick of a frame occurs clock_divider_i+1 cycles after the START entry.
- Bit period is OVERSAMPLE ticks, i.e. 16*(div+1) cycles. Divider 0 means 16 cycles per bit.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE -> START when fifo_empty_i=0 and (flow_control_i=0 or uart_cts_i=1).
  - In that same cycle fifo_read_o=1 and fifo_data_i is latched into the shift register.
  - clock_divider_i, parity and stop configuration are also latched at this point. Configuration changes mid-frame have no effect.
- uart_tx_o=0 from the cycle after the pop, so latency from the pop cycle is 1 cycle.
- START -> DATA after 1 bit period.
- DATA shifts the register right once per bit period, uart_tx_o = bit0 (LSB first). After DATA_WIDTH bits, go to PARITY if enabled, else STOP.
- PARITY drives XOR of the latched data word, inverted when parity_odd, for 1 bit period. Then go to STOP.
- STOP drives uart_tx_o=1 for 1 or 2 bit periods. On its final cycle tx_done_o=1 and the FSM goes to IDLE.
  - If the next frame's conditions hold in that IDLE cycle, the pop happens there. Gap between frames is exactly 1 clk_i cycle of high line.
- CTS is sampled only in IDLE. Deassertion mid-frame never truncates the current frame. With CTS low and data pending, the FSM waits in IDLE with no pop.
- Frame length in cycles = (1+DATA_WIDTH+P+S)*16*(div+1), with P in {0,1} and S in {1,2}.
- Reset asserted mid-frame: uart_tx_o returns high immediately. The partial byte is lost and not re-popped.
- fifo_read_o is never asserted when fifo_empty_i=1.

Decomposition:
- Package uart_pkg holds:
  - uart_tx_state_t enum {IDLE, START, DATA, PARITY, STOP};
  - localparam OVERSAMPLE=16;
  - a parity function taking data and odd flag.
  - These sit alongside the existing STATUS/register typedefs.
- One sub-module, uart_baud_generator: divider counter with clear input and tick output. It is shared later with the receiver, which samples mid-bit at tick 8.

Test Plan:
- div=0, no parity, 1 stop, push 0x55 -> pop at cycle T. Line low at T+1 for 16 cycles, then 1,0,1,0,1,0,1,0 at 16 cycles each, then high. tx_done_o pulses at T+160.
- div=0, even parity, send 0x07 -> parity bit 1. Odd parity, send 0x07 -> parity bit 0. Frame is 176 cycles.
- div=53, two stop bits, send 0xA3 -> each bit 864 cycles. Frame 11*864=9504 cycles. Received byte on loopback uart_rx_i equals 0xA3.
- Push 8 bytes 0..7 back-to-back -> 8 pops, in order, each separated by exactly one frame plus 1 idle cycle, and 8 tx_done_o pulses.
- flow_control_i=1, uart_cts_i=0, FIFO non-empty -> no pop, line high, idle_o=1. Raise CTS -> pop next cycle. Drop CTS mid-frame -> frame completes.
- Assert rst_n_i low during DATA of 0xFF -> uart_tx_o=1 asynchronously and idle_o=1. After release, the next FIFO entry is sent and no re-pop of the lost byte occurs.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART types, constants and helpers for the TX/RX datapaths.
package uart_pkg;

  localparam int unsigned OVERSAMPLE     = 16;
  localparam int unsigned DIV_WIDTH      = 15;
  localparam int unsigned MAX_DATA_WIDTH = 9;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_tx_state_t;

  // Frame configuration captured when a byte is popped.
  typedef struct packed {
    logic [DIV_WIDTH-1:0] clock_divider;
    logic                 parity_enable;
    logic                 stop_bits;
  } uart_tx_cfg_t;

  function automatic logic uart_parity(input logic [MAX_DATA_WIDTH-1:0] data,
                                       input logic                      odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_baud_generator.sv
// Oversampling tick source: one-cycle tick every divider+1 cycles, held at zero by clear.
module uart_baud_generator
  import uart_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic [DIV_WIDTH-1:0] divider,
  output logic                 tick
);

  logic [DIV_WIDTH-1:0] count;

  assign tick = !clear && (count == divider);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear || tick) begin
      count <= '0;
    end else begin
      count <= count + DIV_WIDTH'(1);
    end
  end

endmodule

// File: rtl/uart_transmitter.sv
// UART TX serializer: pops the FIFO head and sends start, data LSB-first,
// optional parity and one or two stop bits.
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic [DIV_WIDTH-1:0]  clock_divider_i,
  input  logic                  parity_enable_i,
  input  logic                  parity_odd_i,
  input  logic                  stop_bits_i,
  input  logic                  flow_control_i,
  input  logic                  uart_cts_i,
  input  logic                  fifo_empty_i,
  input  logic [DATA_WIDTH-1:0] fifo_data_i,
  output logic                  fifo_read_o,
  output logic                  uart_tx_o,
  output logic                  tx_done_o,
  output logic                  idle_o
);

  localparam int unsigned BIT_CNT_W  = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
  localparam int unsigned TICK_CNT_W = $clog2(OVERSAMPLE);

  uart_tx_state_t        state, state_next;
  uart_tx_cfg_t          cfg;
  logic [DATA_WIDTH-1:0] shift;
  logic                  parity;
  logic [TICK_CNT_W-1:0] tick_cnt;
  logic [BIT_CNT_W-1:0]  bit_cnt;
  logic                  running;
  logic                  baud_clear;
  logic                  tick;
  logic                  bit_end;
  logic                  last_data;
  logic                  last_stop;
  logic                  pop;

  assign baud_clear = (state == IDLE);
  assign bit_end    = tick && (tick_cnt == TICK_CNT_W'(OVERSAMPLE - 1));
  assign last_data  = (bit_cnt == BIT_CNT_W'(DATA_WIDTH - 1));
  assign last_stop  = !cfg.stop_bits || (bit_cnt == BIT_CNT_W'(1));
  assign idle_o     = (state == IDLE);

  uart_baud_generator u_baud (
    .clk     (clk_i),
    .rst_n   (rst_n_i),
    .clear   (baud_clear),
    .divider (cfg.clock_divider),
    .tick    (tick)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next  = state;
    pop         = 1'b0;
    tx_done_o   = 1'b0;
    uart_tx_o   = 1'b1;
    case (state)
      IDLE: begin
        // running keeps the pop strobe low while reset is held
        if (running && !fifo_empty_i && (!flow_control_i || uart_cts_i)) begin
          pop        = 1'b1;
          state_next = START;
        end
      end
      START: begin
        uart_tx_o = 1'b0;
        if (bit_end) state_next = DATA;
      end
      DATA: begin
        uart_tx_o = shift[0];
        if (bit_end && last_data) state_next = cfg.parity_enable ? PARITY : STOP;
      end
      PARITY: begin
        uart_tx_o = parity;
        if (bit_end) state_next = STOP;
      end
      STOP: begin
        if (bit_end && last_stop) begin
          tx_done_o  = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    fifo_read_o = pop;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      running  <= 1'b0;
      cfg      <= '0;
      shift    <= '0;
      parity   <= 1'b0;
      tick_cnt <= '0;
      bit_cnt  <= '0;
    end else begin
      running <= 1'b1;
      if (state == IDLE) begin
        tick_cnt <= '0;
        bit_cnt  <= '0;
        if (pop) begin
          shift  <= fifo_data_i;
          parity <= uart_parity(MAX_DATA_WIDTH'(fifo_data_i), parity_odd_i);
          cfg    <= '{clock_divider: clock_divider_i,
                      parity_enable: parity_enable_i,
                      stop_bits:     stop_bits_i};
        end
      end else if (tick) begin
        tick_cnt <= bit_end ? '0 : tick_cnt + TICK_CNT_W'(1);
        if (bit_end) begin
          if (state == DATA) shift <= shift >> 1;
          // bit_cnt restarts whenever the bit type changes
          bit_cnt <= (state_next != state) ? '0 : bit_cnt + BIT_CNT_W'(1);
        end
      end
    end
  end

endmodule
